// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles 32-bit words from a little-endian byte
// stream and writes them to consecutive word addresses, keeping a running XOR
// checksum of every word written in the current load.
module imem_loader #(
  parameter int ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_num_words,
  input  logic              i_abort,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte,
  output logic              o_byte_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [31:0]       o_checksum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W-1:0]   word_cnt;
  logic [1:0]          byte_idx;
  logic [23:0]         byte_buf;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [31:0]         wr_data_q;
  logic [31:0]         checksum_q;
  logic                byte_take;
  logic                last_word;

  // A byte is consumed only while receiving; abort discards it.
  assign byte_take = (state == RECV) && i_byte_valid && !i_abort;
  // Counter is one bit narrower than the count, so a full 2^ADDR_W load ends at the top address.
  assign last_word = ({1'b0, word_cnt} == (count_q - ONE));

  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_checksum = checksum_q;

  // State register; reset overrides start and abort.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control outputs; abort in WRITE suppresses the strobe.
  always_comb begin
    state_nxt    = state;
    o_byte_ready = 1'b0;
    o_wr_en      = 1'b0;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          state_nxt = (i_num_words == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        o_byte_ready = 1'b1;
        if (i_abort) begin
          state_nxt = IDLE;
        end else if (byte_take && (byte_idx == 2'd3)) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (i_abort) begin
          state_nxt = IDLE;
        end else begin
          o_wr_en   = 1'b1;
          state_nxt = last_word ? DONE : RECV;
        end
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: latch the load, gather bytes, and capture each finished word so
  // the write address/data stay stable between strobes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q    <= '0;
      word_cnt   <= '0;
      byte_idx   <= '0;
      byte_buf   <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      checksum_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            count_q    <= i_num_words;
            word_cnt   <= '0;
            byte_idx   <= '0;
            checksum_q <= '0;
          end
        end
        RECV: begin
          if (byte_take) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: byte_buf[7:0]   <= i_byte;
              2'd1: byte_buf[15:8]  <= i_byte;
              2'd2: byte_buf[23:16] <= i_byte;
              default: begin
                wr_data_q <= {i_byte, byte_buf};
                wr_addr_q <= word_cnt;
              end
            endcase
          end
        end
        WRITE: begin
          if (!i_abort) begin
            checksum_q <= checksum_q ^ wr_data_q;
            if (!last_word) begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a table of load scenarios streams bytes
// into the loader, expected writes go into a scoreboard queue as words are
// driven, and a monitor pops and compares every write strobe.
module tb_imem_loader;

  localparam int ADDR_W = 12;

  logic              i_clk;
  logic              i_reset;
  logic              i_start;
  logic [ADDR_W:0]   i_num_words;
  logic              i_abort;
  logic              i_byte_valid;
  logic [7:0]        i_byte;
  logic              o_byte_ready;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [31:0]       o_wr_data;
  logic              o_busy;
  logic              o_done;
  logic [31:0]       o_checksum;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_num_words  (i_num_words),
    .i_abort      (i_abort),
    .i_byte_valid (i_byte_valid),
    .i_byte       (i_byte),
    .o_byte_ready (o_byte_ready),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_checksum   (o_checksum)
  );

  typedef struct {
    logic [ADDR_W:0]  num;
    logic [3:0][31:0] w;
    int               gap_max;
    int               abort_after;
    bit               start_mid;
    bit               abort_with_start;
    int               exp_busy;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t  wr_q[$];
  int   n_vec;
  int   n_fail;
  int   writes_seen;
  int   done_count;
  int   busy_cycles;
  logic [ADDR_W-1:0] last_addr;

  // Free-running clock.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor on the falling edge: score every write strobe against the queue
  // and count done pulses and busy cycles.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_wr_en) begin
        if (wr_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("[TB] FAIL unexpected_write: got addr 0x%03h data 0x%08h expected no write", o_wr_addr, o_wr_data);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          check("wr_addr", 32'(o_wr_addr), 32'(e.addr));
          check("wr_data", o_wr_data, e.data);
        end
        writes_seen++;
        last_addr = o_wr_addr;
      end
      if (o_done) done_count++;
      if (o_busy) busy_cycles++;
    end
  end

  function automatic vec_t mk(input int num, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3, input int gap_max,
                              input int abort_after, input bit start_mid, input bit abort_with_start,
                              input int exp_busy);
    vec_t v;
    v.num = (ADDR_W+1)'(num);
    v.w[0] = w0;
    v.w[1] = w1;
    v.w[2] = w2;
    v.w[3] = w3;
    v.gap_max = gap_max;
    v.abort_after = abort_after;
    v.start_mid = start_mid;
    v.abort_with_start = abort_with_start;
    v.exp_busy = exp_busy;
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  // Present one byte after an idle gap and hold it until the loader takes it.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    i_byte_valid = 1'b0;
    repeat (gap) next_cycle();
    i_byte_valid = 1'b1;
    i_byte = b;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge i_clk);
      got = o_byte_ready;
      next_cycle();
    end
    i_byte_valid = 1'b0;
    i_byte = 8'($urandom);
    if (!got) begin
      n_vec++;
      n_fail++;
      $display("[TB] FAIL byte_accept_timeout: got no ready expected ready within 50 cycles");
    end
  endtask

  // Run one load: start, stream bytes, push expected writes as words are driven.
  task automatic applyStimulus(input vec_t v, output logic [31:0] cks, output int nwr);
    int sent;
    logic [31:0] word;
    bit stop;
    cks = '0;
    nwr = 0;
    sent = 0;
    stop = 1'b0;
    writes_seen = 0;
    done_count = 0;
    busy_cycles = 0;
    i_start = 1'b1;
    i_num_words = v.num;
    i_abort = v.abort_with_start;
    next_cycle();
    i_start = 1'b0;
    i_abort = 1'b0;
    i_num_words = (ADDR_W+1)'(1);
    for (int wd = 0; wd < int'(v.num) && !stop; wd++) begin
      word = (wd < 4) ? v.w[wd] : $urandom;
      for (int k = 0; k < 4 && !stop; k++) begin
        if (sent == v.abort_after) begin
          stop = 1'b1;
        end else begin
          if (v.start_mid && sent == 1) i_start = 1'b1;
          send_byte(word[8*k +: 8], (v.gap_max > 0) ? int'($urandom_range(v.gap_max, 0)) : 0);
          i_start = 1'b0;
          sent++;
          if (k == 3) begin
            wr_q.push_back('{addr: ADDR_W'(wd), data: word});
            cks ^= word;
            nwr++;
          end
        end
      end
    end
    if (v.abort_after >= 0) begin
      i_abort = 1'b1;
      next_cycle();
      i_abort = 1'b0;
    end
  endtask

  // Wait for the load to finish and compare the end-of-load state.
  task automatic checkOutput(input vec_t v, input logic [31:0] cks, input int nwr);
    bit exp_done;
    exp_done = (v.abort_after < 0);
    for (int t = 0; t < 40 && exp_done && done_count == 0; t++) next_cycle();
    if (!exp_done) repeat (3) next_cycle();
    check("done_pulses", 32'(done_count), exp_done ? 32'd1 : 32'd0);
    check("done_low_after", 32'(o_done), 32'd0);
    check("busy_idle", 32'(o_busy), 32'd0);
    check("checksum", o_checksum, cks);
    check("write_count", 32'(writes_seen), 32'(nwr));
    check("queue_empty", 32'(wr_q.size()), 32'd0);
    if (v.exp_busy >= 0) check("busy_cycles", 32'(busy_cycles), 32'(v.exp_busy));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(o_byte_ready), 32'd0);
    check({tag, "_wr_en"}, 32'(o_wr_en), 32'd0);
    check({tag, "_wr_addr"}, 32'(o_wr_addr), 32'd0);
    check({tag, "_wr_data"}, o_wr_data, 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_checksum"}, o_checksum, 32'd0);
  endtask

  initial begin
    vec_t vecs[6];
    vec_t big;
    logic [31:0] cks;
    int nwr;

    n_vec = 0;
    n_fail = 0;
    writes_seen = 0;
    done_count = 0;
    busy_cycles = 0;
    last_addr = '0;
    i_reset = 1'b1;
    i_start = 1'b0;
    i_num_words = '0;
    i_abort = 1'b0;
    i_byte_valid = 1'b0;
    i_byte = 8'h00;

    vecs[0] = mk(1, 32'h00000013, 0, 0, 0, 0, -1, 0, 0, 6);
    vecs[1] = mk(3, 32'h00500093, 32'h00100113, 32'h002081B3, 0, 3, -1, 0, 0, -1);
    vecs[2] = mk(0, 0, 0, 0, 0, 0, -1, 0, 0, 1);
    vecs[3] = mk(2, 32'hDEADBEEF, 32'h12345678, 0, 0, 0, 6, 0, 0, -1);
    vecs[4] = mk(3, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h80000001, 0, 1, -1, 1, 0, -1);
    vecs[5] = mk(4, 32'h11111111, 32'h22222222, 32'h44444444, 32'h88888888, 0, -1, 0, 1, 21);

    repeat (2) next_cycle();
    check_reset_values("reset");
    i_reset = 1'b0;
    next_cycle();

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], cks, nwr);
      checkOutput(vecs[i], cks, nwr);
      next_cycle();
    end

    // Abort while the write strobe would be issued: the write must vanish.
    writes_seen = 0;
    done_count = 0;
    i_start = 1'b1;
    i_num_words = (ADDR_W+1)'(2);
    next_cycle();
    i_start = 1'b0;
    for (int k = 0; k < 4; k++) send_byte(8'(k + 1), 0);
    i_abort = 1'b1;
    next_cycle();
    i_abort = 1'b0;
    repeat (2) next_cycle();
    check("abort_write_count", 32'(writes_seen), 32'd0);
    check("abort_write_cks", o_checksum, 32'd0);
    check("abort_write_done", 32'(done_count), 32'd0);
    check("abort_write_busy", 32'(o_busy), 32'd0);

    // Abort during DONE does not cut the pulse short.
    done_count = 0;
    i_start = 1'b1;
    i_num_words = '0;
    next_cycle();
    i_start = 1'b0;
    i_abort = 1'b1;
    next_cycle();
    i_abort = 1'b0;
    next_cycle();
    check("abort_in_done_pulse", 32'(done_count), 32'd1);

    // Reset partway through the second word: one write, then everything clears.
    writes_seen = 0;
    i_start = 1'b1;
    i_num_words = (ADDR_W+1)'(2);
    next_cycle();
    i_start = 1'b0;
    wr_q.push_back('{addr: '0, data: 32'hCAFEF00D});
    for (int k = 0; k < 4; k++) send_byte(8'(32'hCAFEF00D >> (8*k)), 0);
    send_byte(8'h77, 0);
    send_byte(8'h66, 0);
    i_reset = 1'b1;
    i_start = 1'b1;
    i_abort = 1'b1;
    next_cycle();
    check_reset_values("midreset");
    check("midreset_writes", 32'(writes_seen), 32'd1);
    i_reset = 1'b0;
    i_start = 1'b0;
    i_abort = 1'b0;
    next_cycle();

    // Full-size load reaches the top address without wrapping.
    big = mk(4096, 32'h00000001, 32'h00000002, 32'h00000004, 32'h00000008, 0, -1, 0, 0, 4096*5 + 1);
    applyStimulus(big, cks, nwr);
    checkOutput(big, cks, nwr);
    check("big_last_addr", 32'(last_addr), 32'd4095);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 12, word-address width of the target instruction memory (4096 words).
REQ-002 i_clk  in  1  single clock; all state changes on rising edge.
REQ-003 i_reset  in  1  synchronous, active-high reset.
REQ-004 i_start  in  1  one-cycle load request; sampled only in IDLE.
REQ-005 i_num_words  in  ADDR_W+1  words to load, latched on accepted i_start; legal 0..2^ADDR_W.
REQ-006 i_abort  in  1  cancel the load in progress.
REQ-007 i_byte_valid  in  1  byte stream valid.
REQ-008 i_byte  in  8  byte stream data, least-significant byte of each word first.
REQ-009 o_byte_ready  out  1  loader accepts a byte this cycle.
REQ-010 o_wr_en  out  1  instruction-memory write strobe, one cycle per word.
REQ-011 o_wr_addr  out  ADDR_W  word address of the write (byte address = o_wr_addr*4).
REQ-012 o_wr_data  out  32  assembled instruction word.
REQ-013 o_busy  out  1  high in every state except IDLE.
REQ-014 o_done  out  1  one-cycle pulse after the final word is written.
REQ-015 o_checksum  out  32  XOR of all words written in the current or most recent load.

Function
REQ-016 States: IDLE, RECV, WRITE, DONE; no other states reachable.
REQ-017 IDLE: o_byte_ready=0; i_start=1 latches i_num_words, clears word counter, byte index and o_checksum; goes to RECV, or to DONE if i_num_words=0.
REQ-018 RECV: o_byte_ready=1; byte accepted only when i_byte_valid&o_byte_ready; byte k (k=0..3) stored in bits [8k+7:8k].
REQ-019 RECV: after the 4th accepted byte, next state is WRITE; byte index wraps to 0.
REQ-020 WRITE: o_byte_ready=0, o_wr_en=1 for exactly one cycle, o_wr_addr=word counter, o_wr_data=assembled word; o_checksum updated with the word in the same edge.
REQ-021 WRITE exit: if word counter = latched count-1, go to DONE; otherwise increment word counter, go to RECV.
REQ-022 Word counter starts at 0; maximum load of 2^ADDR_W words ends at address 2^ADDR_W-1 without wrap.
REQ-023 DONE: o_done=1 for one cycle, then IDLE.
REQ-024 Minimum throughput: 5 cycles per word (4 accept cycles + 1 write cycle).
REQ-025 i_abort=1 in RECV or WRITE: next state IDLE; a write in that same cycle is suppressed (o_wr_en=0); o_done not asserted; o_checksum retains the value from words already written.
REQ-026 i_abort in IDLE or DONE has no effect; in DONE the pulse completes.
REQ-027 i_start outside IDLE ignored; i_start and i_abort together in IDLE: start wins.
REQ-028 Bytes presented while o_byte_ready=0 are neither consumed nor stored.
REQ-029 o_wr_addr and o_wr_data are don't-care when o_wr_en=0 but hold their last value (no toggling).

Reset
REQ-030 i_reset=1 at a rising edge forces IDLE from any state, overriding i_start and i_abort.
REQ-031 Reset values: o_byte_ready=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_busy=0, o_done=0, o_checksum=0; counters and byte index 0.
REQ-032 Reset mid-word discards partial bytes; no write strobe issued in the reset cycle.

Verification
REQ-033 i_num_words=1, bytes 13,00,00,00 back-to-back -> one o_wr_en at addr 0, data 0x00000013, o_done 1 cycle later, o_checksum 0x00000013.
REQ-034 i_num_words=3, words 0x00500093, 0x00100113, 0x002081B3 with random valid gaps -> writes at addr 0,1,2 in order, exactly 3 strobes, checksum = XOR of the three words.
REQ-035 i_num_words=0 -> o_busy high 1 cycle (DONE), o_done pulse, no o_wr_en, o_checksum 0.
REQ-036 i_num_words=2, i_abort after 6 bytes -> one write at addr 0 only, no o_done, IDLE next cycle; new i_start then loads from addr 0.
REQ-037 i_reset asserted after 2 bytes of word 1 -> all outputs at reset values next cycle, no write; i_start with i_num_words=4096 and full stream -> last write at addr 4095, then o_done.
REQ-038 i_start pulsed during RECV -> ignored, latched count and addresses unchanged.
